des_encrypt_iter: RTL and testbench

Iterative single-block DES encryptor, the transmit-side counterpart of the team's DES decryption core. It takes a 64-bit plaintext block and a 64-bit key and runs the 16 Feistel rounds one per clock (two per clock optionally). It computes round subkeys on the fly by rotating C/D in the forward direction rather than storing a 16-entry key table. The block sits between the image-block fetch logic and the ciphertext writer, using the same enable/done/ack handshake as the decryption core.

---
 rtl/des_encrypt_iter.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_des_encrypt_iter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/des_encrypt_iter.sv
// Iterative DES encryptor: one Feistel round per clock, subkeys derived on the fly from C/D.
// Optional build macro DES_UNROLL2_EN cascades two rounds per clock (9-cycle latency).
module des_encrypt_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] message,
    input  logic [63:0] des_key,
    input  logic        ack,
    output logic [63:0] encrypted,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
        logic [27:0] c;
        logic [27:0] d;
    } des_state_t;

`ifdef DES_UNROLL2_EN
    localparam logic [3:0] ROUND_INC  = 4'd2;
    localparam logic [3:0] LAST_ROUND = 4'd14;
`else
    localparam logic [3:0] ROUND_INC  = 4'd1;
    localparam logic [3:0] LAST_ROUND = 4'd15;
`endif

    // Tables use DES bit numbering: entry t selects input bit t, where bit 1 is the MSB.
    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Each box is stored row-major: index = {row, column} = {b1, b6, b2..b5}.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[5'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  g;
        x = e_perm(r) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            g = x[6'(47 - 6 * b) -: 6];
            s[5'(31 - 4 * b) -: 4] = 4'(SBOX[3'(b)][{g[5], g[0], g[4:1]}]);
        end
        return p_perm(s);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    // rnd is the zero-based round index; rounds 1, 2, 9 and 16 rotate by one.
    function automatic des_state_t round_step(input des_state_t s, input logic [3:0] rnd);
        des_state_t n;
        logic       two;
        logic [47:0] k;
        two = !(rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15);
        n.c = rotl(s.c, two);
        n.d = rotl(s.d, two);
        k   = pc2_perm({n.c, n.d});
        n.l = s.r;
        n.r = s.l ^ f_func(s.r, k);
        return n;
    endfunction

    state_t      state_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  round_q;
    logic [63:0] encrypted_q;
    logic        done_q, busy_q;

    des_state_t  cur_s, round_d;
    logic [63:0] ip_d, final_d;
    logic [55:0] pc1_d;

    assign cur_s   = {l_q, r_q, c_q, d_q};
    assign ip_d    = ip_perm(message);
    assign pc1_d   = pc1_perm(des_key);
    assign final_d = fp_perm({r_q, l_q});

`ifdef DES_UNROLL2_EN
    des_state_t step1_d;
    assign step1_d = round_step(cur_s, round_q);
    assign round_d = round_step(step1_d, round_q + 4'd1);
`else
    assign round_d = round_step(cur_s, round_q);
`endif

    // NOTE: every register, including the datapath, is cleared by reset so an aborted
    // block leaves no key or plaintext material behind; all state updates use <=.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            round_q     <= '0;
            encrypted_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        l_q     <= ip_d[63:32];
                        r_q     <= ip_d[31:0];
                        c_q     <= pc1_d[55:28];
                        d_q     <= pc1_d[27:0];
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    l_q     <= round_d.l;
                    r_q     <= round_d.r;
                    c_q     <= round_d.c;
                    d_q     <= round_d.d;
                    round_q <= round_q + ROUND_INC;
                    if (round_q == LAST_ROUND) begin
                        state_q <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    encrypted_q <= final_d;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    // ack wins over a simultaneous enable; the request must come again in IDLE.
                    if (ack) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign encrypted = encrypted_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_des_encrypt_iter.sv
// Self-checking bench for des_encrypt_iter: known-answer vector table with a result
// scoreboard, plus reset-abort and handshake corner-case sequences.
module tb_des_encrypt_iter;

`ifdef DES_UNROLL2_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 17;
`endif

    typedef struct {
        logic [63:0] key;
        logic [63:0] pt;
        logic [63:0] ct;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [63:0] message;
    logic [63:0] des_key;
    logic        ack;
    logic [63:0] encrypted;
    logic        done;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cycle = 0;
    logic [63:0] sb_q [$];
    vec_t        vecs [7];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    des_encrypt_iter dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .message   (message),
        .des_key   (des_key),
        .ack       (ack),
        .encrypted (encrypted),
        .done      (done),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge with the DUT in IDLE; returns at the falling edge after capture.
    task automatic start_block(input logic [63:0] key, input logic [63:0] pt,
                               input logic [63:0] exp, input bit track, output int t0);
        message = pt;
        des_key = key;
        enable  = 1'b1;
        if (track) sb_q.push_back(exp);
        @(negedge clk);
        t0      = cycle;
        enable  = 1'b0;
        message = {$urandom(), $urandom()};
        des_key = {$urandom(), $urandom()};
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    // n0 is the number of edges already elapsed since the capture edge.
    task automatic wait_done(input string name, input int n0);
        int n;
        n = n0;
        while (done !== 1'b1 && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check({name, "_done_timeout"}, 64'(done), 64'd1);
        end else begin
            check({name, "_latency"}, 64'(n), 64'(LAT));
            check({name, "_busy_in_done"}, 64'(busy), 64'd0);
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s_scoreboard: got done with no queued result, required none", name);
            end else begin
                check(name, encrypted, sb_q.pop_front());
            end
        end
    endtask

    task automatic ack_block(input string name, input logic [63:0] exp);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({name, "_done_after_ack"}, 64'(done), 64'd0);
        check({name, "_hold_after_ack"}, encrypted, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0, t_prev;
        bit  saw;

        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};
        vecs[1] = '{64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
        vecs[2] = '{64'h123556789ABDDEF0, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};
        vecs[3] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58};
        vecs[5] = '{64'h0101010101010101, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
        vecs[6] = '{64'hECCBA8866443200E, 64'hFEDCBA9876543210, 64'h7A17ECABF0F54BFA};

        reset   = 1'b1;
        enable  = 1'b0;
        ack     = 1'b0;
        message = '0;
        des_key = '0;
        repeat (3) @(negedge clk);
        check("reset_encrypted", encrypted, 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back table: ack the cycle after done, restart immediately.
        t_prev = 0;
        for (int i = 0; i < 7; i++) begin
            start_block(vecs[i].key, vecs[i].pt, vecs[i].ct, 1'b1, t0);
            if (i > 0) check("start_period", 64'(t0 - t_prev), 64'(LAT + 2));
            t_prev = t0;
            wait_done($sformatf("vec%0d", i), 0);
            ack_block($sformatf("vec%0d", i), vecs[i].ct);
        end

        // Reset in the middle of the rounds aborts the block with no trailing done.
        start_block(vecs[0].key, vecs[0].pt, vecs[0].ct, 1'b0, t0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_encrypted", encrypted, 64'd0);
        check("midrun_reset_done", 64'(done), 64'd0);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        check("no_residual_activity", 64'(saw), 64'd0);
        start_block(vecs[0].key, vecs[0].pt, vecs[0].ct, 1'b1, t0);
        wait_done("rerun_after_reset", 0);
        ack_block("rerun_after_reset", vecs[0].ct);

        // enable pulsed during ROUND must not disturb the running block.
        start_block(vecs[0].key, vecs[0].pt, vecs[0].ct, 1'b1, t0);
        repeat (3) @(negedge clk);
        message = vecs[1].pt;
        des_key = vecs[1].key;
        enable  = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        wait_done("enable_in_round", 4);

        // done holds while ack stays low.
        repeat (10) begin
            @(negedge clk);
            check("done_held", 64'(done), 64'd1);
        end
        check("result_held", encrypted, vecs[0].ct);

        // enable together with ack in DONE: back to IDLE, nothing captured.
        message = vecs[4].pt;
        des_key = vecs[4].key;
        enable  = 1'b1;
        ack     = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        ack     = 1'b0;
        check("enable_ack_done_low", 64'(done), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("enable_ack_no_capture", 64'(busy), 64'd0);
        end
        check("enable_ack_result_kept", encrypted, vecs[0].ct);

        start_block(vecs[3].key, vecs[3].pt, vecs[3].ct, 1'b1, t0);
        wait_done("after_enable_ack", 0);
        ack_block("after_enable_ack", vecs[3].ct);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
